alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Initiator side of the RCU↔ALU request/response interface.
- Buffers ALU micro-ops dispatched by the RCU until both source operands are available, captures operand values from writeback broadcasts, and issues at most one request per cycle, oldest-ready first.
- The ALU has no ready signal, so every issued request is consumed in the same cycle.
- The ALU's own response is fed back as a wakeup source.

Parameters:
- DEPTH, 4, number of queue entries (≥2).
- XLEN, 64, operand/result width.
- ROB_INDEX_WIDTH, 6, ROB tag width.
- PHY_REG_ADDR_WIDTH, 6, physical register tag width.
- VIRTUAL_ADDR_LEN, 39, pc width.
- CTRL_W, 10, opaque control bundle {half, alu_func_sel[2:0], func_modifier, cmp_func_sel[2:0], is_jump, is_branch}.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  kill all queued and issuing ops
- enq_valid_i  in  1  dispatch valid
- enq_ready_o  out  1  space available
- enq_ctrl_i  in  CTRL_W  control bundle
- enq_prs1_i / enq_prs2_i  in  PHY_REG_ADDR_WIDTH each  source tags
- enq_rdy1_i / enq_rdy2_i  in  1 each  operand value already valid
- enq_opr1_i / enq_opr2_i  in  XLEN each  operand value (or immediate) when rdy
- enq_prd_i  in  PHY_REG_ADDR_WIDTH  destination tag
- enq_rob_index_i  in  ROB_INDEX_WIDTH  ROB tag
- enq_pc_i / enq_next_pc_i  in  VIRTUAL_ADDR_LEN each  pc, pc+4
- wb0_valid_i, wb0_prd_i, wb0_data_i  in  1/PHY_REG_ADDR_WIDTH/XLEN  ALU response broadcast
- wb1_valid_i, wb1_prd_i, wb1_data_i  in  1/PHY_REG_ADDR_WIDTH/XLEN  second writeback broadcast
- alu_req_valid_o  out  1  request to ALU
- alu_ctrl_o  out  CTRL_W  issued control bundle
- alu_opr1_o / alu_opr2_o  out  XLEN each  issued operands
- alu_prd_o  out  PHY_REG_ADDR_WIDTH  issued destination tag
- alu_rob_index_o  out  ROB_INDEX_WIDTH  issued ROB tag
- alu_pc_o / alu_next_pc_o  out  VIRTUAL_ADDR_LEN each  issued pc, pc+4
- count_o  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst high at an edge):
  - all entries invalid; issue register invalid; count_o=0; enq_ready_o=1.
  - alu_req_valid_o=0; all alu_*_o data outputs 0.
- Storage is a collapsing queue held in age order; slot 0 is the oldest.
- Removal shifts younger entries down one slot.
- Enqueue writes the first free slot after the shift.
- enq_ready_o = (count_o < DEPTH), from registered state only.
  - An issue in the same cycle does not free space early.
- Enqueue handshake is enq_valid_i & enq_ready_o at the edge; the entry is valid from the next cycle.
- Wakeup: each cycle, every valid entry's non-ready source whose tag equals wbX_prd_i with wbX_valid_i set captures wbX_data_i and sets ready at the edge.
  - Applies to both sources and both buses.
  - If both buses match, wb0 wins.
- Wakeup also applies to the enqueuing op: a non-ready enq source matching a same-cycle broadcast is stored ready with the broadcast data, so no wakeup is lost.
- Select: the lowest-index valid entry with both sources ready.
  - At the edge it is copied into the issue register (issue_valid=1) and removed from the queue.
  - No eligible entry → issue_valid=0.
- Eligibility uses registered ready bits only. A wakeup at cycle k makes the entry selectable in k+1, with the request visible in k+2.
- Minimum latency: enqueue handshake in cycle 0 with both rdy=1 → alu_req_valid_o high in cycle 2.
- Issue rate: at most one request per cycle; back-to-back issue every cycle is required when ready entries exist.
- alu_req_valid_o = issue_valid & ~flush_i. All alu_*_o outputs come straight from the issue register.
- count_o updates each edge as count + enq_fire − issue_fire.
  - Enqueue and issue in the same cycle with a full queue: not possible, since enq_ready_o=0.
  - Enqueue and issue in the same cycle with a non-full queue: count unchanged.
- Flush: flush_i high at an edge invalidates all entries and the issue register, and sets count to 0.
  - A same-cycle enqueue is dropped.
  - The next cycle has no request.
  - flush_i has priority over enqueue, wakeup and select.
- rst has priority over flush_i.
- An entry's tag match against its own prd is not special-cased.

Test Plan:
- Reset, then enqueue op (rdy1=rdy2=1, opr1=5, opr2=7, prd=3, rob=9) in cycle 0 → cycle 2: alu_req_valid_o=1, opr1=5, opr2=7, prd=3, rob_index=9; cycle 3: alu_req_valid_o=0, count_o=0.
- Enqueue A (prs1=12, not ready) then B (both ready) → B issues first; wb0 (prd=12, data=0xAB) in cycle 4 → A issues in cycle 6 with opr1=0xAB.
- Enqueue with prs2=20 not ready while wb1_valid_i=1, prd=20, data=0x55 in the same cycle → op issues 2 cycles later with opr2=0x55.
- Fill 4 entries, none ready → enq_ready_o=0, count_o=4; an extra enq is held; wakeup of entry 0 → it issues, enq_ready_o returns to 1 the cycle after removal.
- Four ready entries enqueued back-to-back → four consecutive alu_req_valid_o cycles in enqueue order (rob 0,1,2,3).
- Queue holding 3 entries with one issuing, assert flush_i with a concurrent enq → alu_req_valid_o low in the flush cycle, count_o=0 next cycle, no further requests.

Source files
------------

// File: rtl/alu_issue_queue.sv
// ALU issue queue: age-ordered collapsing buffer that captures operand wakeups
// and sends the oldest ready micro-op to the ALU, one request per cycle.
module alu_issue_queue #(
  parameter int DEPTH              = 4,
  parameter int XLEN               = 64,
  parameter int ROB_INDEX_WIDTH    = 6,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int VIRTUAL_ADDR_LEN   = 39,
  parameter int CTRL_W             = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          enq_valid_i,
  output logic                          enq_ready_o,
  input  logic [CTRL_W-1:0]             enq_ctrl_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] enq_prs1_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] enq_prs2_i,
  input  logic                          enq_rdy1_i,
  input  logic                          enq_rdy2_i,
  input  logic [XLEN-1:0]               enq_opr1_i,
  input  logic [XLEN-1:0]               enq_opr2_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] enq_prd_i,
  input  logic [ROB_INDEX_WIDTH-1:0]    enq_rob_index_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]   enq_pc_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]   enq_next_pc_i,
  input  logic                          wb0_valid_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] wb0_prd_i,
  input  logic [XLEN-1:0]               wb0_data_i,
  input  logic                          wb1_valid_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] wb1_prd_i,
  input  logic [XLEN-1:0]               wb1_data_i,
  output logic                          alu_req_valid_o,
  output logic [CTRL_W-1:0]             alu_ctrl_o,
  output logic [XLEN-1:0]               alu_opr1_o,
  output logic [XLEN-1:0]               alu_opr2_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0] alu_prd_o,
  output logic [ROB_INDEX_WIDTH-1:0]    alu_rob_index_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]   alu_pc_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]   alu_next_pc_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic                          valid;
    logic [CTRL_W-1:0]             ctrl;
    logic [PHY_REG_ADDR_WIDTH-1:0] prs1;
    logic [PHY_REG_ADDR_WIDTH-1:0] prs2;
    logic                          rdy1;
    logic                          rdy2;
    logic [XLEN-1:0]               opr1;
    logic [XLEN-1:0]               opr2;
    logic [PHY_REG_ADDR_WIDTH-1:0] prd;
    logic [ROB_INDEX_WIDTH-1:0]    rob;
    logic [VIRTUAL_ADDR_LEN-1:0]   pc;
    logic [VIRTUAL_ADDR_LEN-1:0]   npc;
  } entry_t;

  typedef struct packed {
    logic                          valid;
    logic [CTRL_W-1:0]             ctrl;
    logic [XLEN-1:0]               opr1;
    logic [XLEN-1:0]               opr2;
    logic [PHY_REG_ADDR_WIDTH-1:0] prd;
    logic [ROB_INDEX_WIDTH-1:0]    rob;
    logic [VIRTUAL_ADDR_LEN-1:0]   pc;
    logic [VIRTUAL_ADDR_LEN-1:0]   npc;
  } iss_t;

  // Capture a broadcast into any waiting source; wb0 takes precedence over wb1.
  function automatic entry_t wake(input entry_t e,
                                  input logic v0, input logic [PHY_REG_ADDR_WIDTH-1:0] p0,
                                  input logic [XLEN-1:0] d0,
                                  input logic v1, input logic [PHY_REG_ADDR_WIDTH-1:0] p1,
                                  input logic [XLEN-1:0] d1);
    entry_t r;
    r = e;
    if (r.valid && !r.rdy1) begin
      if (v0 && (p0 == r.prs1)) begin
        r.rdy1 = 1'b1;
        r.opr1 = d0;
      end else if (v1 && (p1 == r.prs1)) begin
        r.rdy1 = 1'b1;
        r.opr1 = d1;
      end
    end
    if (r.valid && !r.rdy2) begin
      if (v0 && (p0 == r.prs2)) begin
        r.rdy2 = 1'b1;
        r.opr2 = d0;
      end else if (v1 && (p1 == r.prs2)) begin
        r.rdy2 = 1'b1;
        r.opr2 = d1;
      end
    end
    return r;
  endfunction

  entry_t           r_q [DEPTH];
  iss_t             r_iss;
  logic [CNT_W-1:0] r_count;

  entry_t           w_woke [DEPTH+1];
  entry_t           w_next [DEPTH];
  entry_t           w_enq_raw;
  entry_t           w_enq_entry;
  entry_t           w_sel_entry;
  logic             w_sel_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_enq_ready;
  logic             w_enq_fire;
  logic [CNT_W-1:0] w_enq_slot;
  logic [CNT_W-1:0] w_count_next;

  assign w_enq_ready = (r_count < CNT_W'(DEPTH));
  assign w_enq_fire  = enq_valid_i & w_enq_ready;

  always_comb begin
    w_enq_raw       = '0;
    w_enq_raw.valid = 1'b1;
    w_enq_raw.ctrl  = enq_ctrl_i;
    w_enq_raw.prs1  = enq_prs1_i;
    w_enq_raw.prs2  = enq_prs2_i;
    w_enq_raw.rdy1  = enq_rdy1_i;
    w_enq_raw.rdy2  = enq_rdy2_i;
    w_enq_raw.opr1  = enq_opr1_i;
    w_enq_raw.opr2  = enq_opr2_i;
    w_enq_raw.prd   = enq_prd_i;
    w_enq_raw.rob   = enq_rob_index_i;
    w_enq_raw.pc    = enq_pc_i;
    w_enq_raw.npc   = enq_next_pc_i;
    w_enq_entry     = wake(w_enq_raw, wb0_valid_i, wb0_prd_i, wb0_data_i,
                           wb1_valid_i, wb1_prd_i, wb1_data_i);
  end

  // Oldest-ready select uses only registered ready bits.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_sel_found && r_q[i].valid && r_q[i].rdy1 && r_q[i].rdy2) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_entry = r_q[i];
      end
    end
  end

  // Collapse above the issued slot, then append the new op after the last valid entry.
  always_comb begin
    w_woke[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_woke[i] = wake(r_q[i], wb0_valid_i, wb0_prd_i, wb0_data_i,
                       wb1_valid_i, wb1_prd_i, wb1_data_i);
    end
    w_enq_slot = r_count - CNT_W'(w_sel_found);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_found && (IDX_W'(i) >= w_sel_idx)) begin
        w_next[i] = w_woke[i+1];
      end else begin
        w_next[i] = w_woke[i];
      end
      if (w_enq_fire && (CNT_W'(i) == w_enq_slot)) begin
        w_next[i] = w_enq_entry;
      end
    end
    w_count_next = r_count + CNT_W'(w_enq_fire) - CNT_W'(w_sel_found);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_iss   <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_iss.valid <= 1'b0;
      r_count     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= w_next[i];
      r_count     <= w_count_next;
      r_iss.valid <= w_sel_found;
      if (w_sel_found) begin
        r_iss.ctrl <= w_sel_entry.ctrl;
        r_iss.opr1 <= w_sel_entry.opr1;
        r_iss.opr2 <= w_sel_entry.opr2;
        r_iss.prd  <= w_sel_entry.prd;
        r_iss.rob  <= w_sel_entry.rob;
        r_iss.pc   <= w_sel_entry.pc;
        r_iss.npc  <= w_sel_entry.npc;
      end
    end
  end

  assign enq_ready_o     = w_enq_ready;
  assign count_o         = r_count;
  assign alu_req_valid_o = r_iss.valid & ~flush_i;
  assign alu_ctrl_o      = r_iss.ctrl;
  assign alu_opr1_o      = r_iss.opr1;
  assign alu_opr2_o      = r_iss.opr2;
  assign alu_prd_o       = r_iss.prd;
  assign alu_rob_index_o = r_iss.rob;
  assign alu_pc_o        = r_iss.pc;
  assign alu_next_pc_o   = r_iss.npc;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: latency, wakeup, ordering, backpressure and flush.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [9:0]  enq_ctrl_i;
  logic [5:0]  enq_prs1_i, enq_prs2_i;
  logic        enq_rdy1_i, enq_rdy2_i;
  logic [63:0] enq_opr1_i, enq_opr2_i;
  logic [5:0]  enq_prd_i;
  logic [5:0]  enq_rob_index_i;
  logic [38:0] enq_pc_i, enq_next_pc_i;
  logic        wb0_valid_i, wb1_valid_i;
  logic [5:0]  wb0_prd_i, wb1_prd_i;
  logic [63:0] wb0_data_i, wb1_data_i;
  logic        alu_req_valid_o;
  logic [9:0]  alu_ctrl_o;
  logic [63:0] alu_opr1_o, alu_opr2_o;
  logic [5:0]  alu_prd_o;
  logic [5:0]  alu_rob_index_o;
  logic [38:0] alu_pc_o, alu_next_pc_o;
  logic [2:0]  count_o;

  int checks   = 0;
  int failures = 0;

  alu_issue_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_ctrl_i(enq_ctrl_i),
    .enq_prs1_i(enq_prs1_i), .enq_prs2_i(enq_prs2_i),
    .enq_rdy1_i(enq_rdy1_i), .enq_rdy2_i(enq_rdy2_i),
    .enq_opr1_i(enq_opr1_i), .enq_opr2_i(enq_opr2_i),
    .enq_prd_i(enq_prd_i), .enq_rob_index_i(enq_rob_index_i),
    .enq_pc_i(enq_pc_i), .enq_next_pc_i(enq_next_pc_i),
    .wb0_valid_i(wb0_valid_i), .wb0_prd_i(wb0_prd_i), .wb0_data_i(wb0_data_i),
    .wb1_valid_i(wb1_valid_i), .wb1_prd_i(wb1_prd_i), .wb1_data_i(wb1_data_i),
    .alu_req_valid_o(alu_req_valid_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_opr1_o(alu_opr1_o), .alu_opr2_o(alu_opr2_o),
    .alu_prd_o(alu_prd_o), .alu_rob_index_o(alu_rob_index_o),
    .alu_pc_o(alu_pc_o), .alu_next_pc_o(alu_next_pc_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r1, input logic r2,
                               input logic [5:0] p1, input logic [5:0] p2,
                               input logic [63:0] o1, input logic [63:0] o2,
                               input logic [5:0] prd, input logic [5:0] rob);
    enq_valid_i     = 1'b1;
    enq_rdy1_i      = r1;
    enq_rdy2_i      = r2;
    enq_prs1_i      = p1;
    enq_prs2_i      = p2;
    enq_opr1_i      = o1;
    enq_opr2_i      = o2;
    enq_prd_i       = prd;
    enq_rob_index_i = rob;
    enq_ctrl_i      = 10'h2A5;
    enq_pc_i        = 39'h1000 + 39'(rob) * 39'd4;
    enq_next_pc_i   = 39'h1004 + 39'(rob) * 39'd4;
  endtask

  task automatic setWb(input logic v0, input logic [5:0] p0, input logic [63:0] d0,
                       input logic v1, input logic [5:0] p1, input logic [63:0] d1);
    wb0_valid_i = v0; wb0_prd_i = p0; wb0_data_i = d0;
    wb1_valid_i = v1; wb1_prd_i = p1; wb1_data_i = d1;
  endtask

  task automatic idle();
    enq_valid_i = 1'b0;
    enq_rdy1_i = 1'b0; enq_rdy2_i = 1'b0;
    enq_prs1_i = '0; enq_prs2_i = '0; enq_opr1_i = '0; enq_opr2_i = '0;
    enq_prd_i = '0; enq_rob_index_i = '0; enq_ctrl_i = '0;
    enq_pc_i = '0; enq_next_pc_i = '0;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    idle();
    setWb(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_count", 64'(count_o), 64'd0);
    checkOutput("rst_ready", 64'(enq_ready_o), 64'd1);
    checkOutput("rst_valid", 64'(alu_req_valid_o), 64'd0);
    checkOutput("rst_opr1", alu_opr1_o, 64'd0);
    checkOutput("rst_rob", 64'(alu_rob_index_o), 64'd0);

    // Minimum latency: enqueue in cycle 0, request in cycle 2
    applyStimulus(1, 1, 6'd1, 6'd2, 64'd5, 64'd7, 6'd3, 6'd9);
    tick(); idle();
    checkOutput("lat_c1_valid", 64'(alu_req_valid_o), 64'd0);
    checkOutput("lat_c1_count", 64'(count_o), 64'd1);
    tick();
    checkOutput("lat_valid", 64'(alu_req_valid_o), 64'd1);
    checkOutput("lat_opr1", alu_opr1_o, 64'd5);
    checkOutput("lat_opr2", alu_opr2_o, 64'd7);
    checkOutput("lat_prd", 64'(alu_prd_o), 64'd3);
    checkOutput("lat_rob", 64'(alu_rob_index_o), 64'd9);
    checkOutput("lat_ctrl", 64'(alu_ctrl_o), 64'h2A5);
    checkOutput("lat_pc", 64'(alu_pc_o), 64'h1024);
    checkOutput("lat_npc", 64'(alu_next_pc_o), 64'h1028);
    tick();
    checkOutput("lat_c3_valid", 64'(alu_req_valid_o), 64'd0);
    checkOutput("lat_c3_count", 64'(count_o), 64'd0);

    // Younger ready op bypasses older waiting op; wb0 wakes the older one
    applyStimulus(0, 1, 6'd12, 6'd13, 64'd0, 64'd1, 6'd4, 6'd10);
    tick();
    applyStimulus(1, 1, 6'd14, 6'd15, 64'd2, 64'd3, 6'd5, 6'd11);
    tick(); idle();
    tick();
    checkOutput("ooo_c3_valid", 64'(alu_req_valid_o), 64'd1);
    checkOutput("ooo_c3_rob", 64'(alu_rob_index_o), 64'd11);
    tick();
    checkOutput("ooo_c4_valid", 64'(alu_req_valid_o), 64'd0);
    setWb(1, 6'd12, 64'hAB, 0, 0, 0);
    tick();
    setWb(0, 0, 0, 0, 0, 0);
    checkOutput("ooo_c5_valid", 64'(alu_req_valid_o), 64'd0);
    tick();
    checkOutput("ooo_c6_valid", 64'(alu_req_valid_o), 64'd1);
    checkOutput("ooo_c6_rob", 64'(alu_rob_index_o), 64'd10);
    checkOutput("ooo_c6_opr1", alu_opr1_o, 64'hAB);
    checkOutput("ooo_c6_opr2", alu_opr2_o, 64'd1);
    tick();
    checkOutput("ooo_c7_count", 64'(count_o), 64'd0);

    // Enqueue-time wakeup from wb1
    applyStimulus(1, 0, 6'd1, 6'd20, 64'h11, 64'd0, 6'd6, 6'd12);
    setWb(0, 0, 0, 1, 6'd20, 64'h55);
    tick(); idle(); setWb(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("enqwk_valid", 64'(alu_req_valid_o), 64'd1);
    checkOutput("enqwk_opr1", alu_opr1_o, 64'h11);
    checkOutput("enqwk_opr2", alu_opr2_o, 64'h55);
    checkOutput("enqwk_rob", 64'(alu_rob_index_o), 64'd12);
    tick();

    // Both buses match the same tag: wb0 data is captured
    applyStimulus(0, 1, 6'd21, 6'd22, 64'd0, 64'd2, 6'd7, 6'd13);
    tick(); idle();
    setWb(1, 6'd21, 64'h66, 1, 6'd21, 64'h77);
    tick(); setWb(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("prio_valid", 64'(alu_req_valid_o), 64'd1);
    checkOutput("prio_opr1", alu_opr1_o, 64'h66);
    tick();
    checkOutput("prio_after_valid", 64'(alu_req_valid_o), 64'd0);

    // Fill the queue with waiting ops
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 6'(30 + k), 6'd40, 64'd0, 64'(k), 6'(k), 6'(20 + k));
      tick();
    end
    checkOutput("full_count", 64'(count_o), 64'd4);
    checkOutput("full_ready", 64'(enq_ready_o), 64'd0);
    applyStimulus(1, 1, 6'd0, 6'd0, 64'h40, 64'h41, 6'd8, 6'd40);
    setWb(1, 6'd30, 64'h99, 0, 0, 0);
    tick(); setWb(0, 0, 0, 0, 0, 0);
    checkOutput("held_count", 64'(count_o), 64'd4);
    checkOutput("held_ready", 64'(enq_ready_o), 64'd0);
    checkOutput("held_valid", 64'(alu_req_valid_o), 64'd0);
    tick();
    checkOutput("drain_valid", 64'(alu_req_valid_o), 64'd1);
    checkOutput("drain_rob", 64'(alu_rob_index_o), 64'd20);
    checkOutput("drain_opr1", alu_opr1_o, 64'h99);
    checkOutput("drain_count", 64'(count_o), 64'd3);
    checkOutput("drain_ready", 64'(enq_ready_o), 64'd1);
    tick(); idle();
    checkOutput("refill_count", 64'(count_o), 64'd4);
    checkOutput("refill_valid", 64'(alu_req_valid_o), 64'd0);
    tick();
    checkOutput("late_valid", 64'(alu_req_valid_o), 64'd1);
    checkOutput("late_rob", 64'(alu_rob_index_o), 64'd40);
    checkOutput("late_count", 64'(count_o), 64'd3);

    // Flush while a request is visible and an enqueue is offered
    setWb(1, 6'd31, 64'h31, 0, 0, 0);
    tick(); setWb(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 6'd50, 6'd0, 64'd0, 64'd0, 6'd9, 6'd41);
    tick(); idle();
    checkOutput("pre_flush_valid", 64'(alu_req_valid_o), 64'd1);
    checkOutput("pre_flush_rob", 64'(alu_rob_index_o), 64'd21);
    checkOutput("pre_flush_count", 64'(count_o), 64'd3);
    flush_i = 1'b1;
    applyStimulus(1, 1, 6'd0, 6'd0, 64'd1, 64'd1, 6'd10, 6'd42);
    #1;
    checkOutput("flush_valid", 64'(alu_req_valid_o), 64'd0);
    tick();
    flush_i = 1'b0; idle();
    checkOutput("post_flush_count", 64'(count_o), 64'd0);
    checkOutput("post_flush_valid", 64'(alu_req_valid_o), 64'd0);
    checkOutput("post_flush_ready", 64'(enq_ready_o), 64'd1);
    tick(); tick();
    checkOutput("quiet_valid", 64'(alu_req_valid_o), 64'd0);
    checkOutput("quiet_count", 64'(count_o), 64'd0);

    // Back-to-back issue in enqueue order
    for (int k = 0; k < 6; k++) begin
      if (k < 4) applyStimulus(1, 1, 6'd0, 6'd0, 64'(k), 64'd0, 6'd1, 6'(k));
      else idle();
      tick();
      if (k + 1 >= 2 && k + 1 <= 5) begin
        checkOutput("b2b_valid", 64'(alu_req_valid_o), 64'd1);
        checkOutput("b2b_rob", 64'(alu_rob_index_o), 64'(k - 1));
      end else begin
        checkOutput("b2b_idle", 64'(alu_req_valid_o), 64'd0);
      end
      checkOutput("b2b_count", 64'(count_o), (k + 1 <= 4) ? 64'd1 : 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
